// File: rtl/blink_pkg.sv
// blink_pkg: shared types and encodings for the LED blink sequencer.
//   state_e     - sequencer FSM states
//   MODE_*      - encodings of the 2-bit mode input
//   mode2state  - maps a mode value to the FSM state that serves it
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALL   = 2'd1,
    ST_CHASE = 2'd2,
    ST_FILL  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ALL   = 2'd0;
  localparam logic [1:0] MODE_CHASE = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  function automatic state_e mode2state(input logic [1:0] m);
    case (m)
      MODE_ALL:   return ST_ALL;
      MODE_CHASE: return ST_CHASE;
      MODE_FILL:  return ST_FILL;
      default:    return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/toggle_channel.sv
// toggle_channel: one programmable half-period LED toggler.
//   clk, rst_n   clock / async active-low reset
//   en_i         channel enable for the coming cycle (next-state view)
//   wr_valid_i   load wr_delay_i into the pending register
//   wr_delay_i   new delay value
//   led_o        registered LED output
//   pending_o    a delay write is waiting to be applied
module toggle_channel #(
  parameter int CNT_W         = 16,
  parameter int DEFAULT_DELAY = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_valid_i,
  input  logic [CNT_W-1:0] wr_delay_i,
  output logic             led_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cnt_q, dly_q, pdly_q;
  logic             pend_q, led_q, en_q;
  logic             active, hit;

  // Counting only happens while the channel was enabled last cycle and
  // stays enabled; the first enabled edge just parks the counter at phase 0
  // so the first rise lands delay+1 cycles after the enable edge.
  assign active = en_i & en_q;
  assign hit    = active & (cnt_q == dly_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dly_q  <= CNT_W'(DEFAULT_DELAY);
      pdly_q <= '0;
      pend_q <= 1'b0;
      led_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      en_q <= en_i;
      if (!active) begin
        cnt_q <= '0;
        led_q <= 1'b0;
      end else if (hit) begin
        cnt_q <= '0;
        led_q <= ~led_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A running channel takes the new delay at its toggle (the toggle
      // itself used the old one); an idle channel takes it right away.
      if (pend_q && (!active || hit)) begin
        dly_q  <= pdly_q;
        pend_q <= 1'b0;
      end else if (wr_valid_i) begin
        pdly_q <= wr_delay_i;
        pend_q <= 1'b1;
      end
    end
  end

  assign led_o     = led_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: sequences a bank of toggle channels in ALL / CHASE / FILL.
//   clk, rst_n   clock / async active-low reset
//   run          1 = sequencer active
//   mode         0=ALL 1=CHASE 2=FILL 3=OFF
//   cfg_valid/cfg_ready/cfg_ch/cfg_delay  delay-write handshake
//   led          registered channel outputs
//   step_idx     current sequencer step
//   busy         FSM not in IDLE
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int CNT_W         = 16,
  parameter int DWELL         = 1000,
  parameter int DEFAULT_DELAY = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [1:0]                mode,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_delay,
  output logic [NUM_CH-1:0]         led,
  output logic [$clog2(NUM_CH)-1:0] step_idx,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int DW_W = $clog2(DWELL);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   step_q, step_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              go_idle, accept;
  state_e            want;
  logic [NUM_CH-1:0] en_d, wr_vld, pend;

  assign go_idle = !run || (mode == MODE_OFF);
  assign want    = mode2state(mode);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    if (go_idle) begin
      state_d = ST_IDLE;
      step_d  = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ALL: begin
          if (want != state_q) begin
            state_d = want;
            step_d  = '0;
            dwell_d = '0;
          end
        end
        default: begin
          // CHASE/FILL only react to mode at the dwell boundary
          if (dwell_q == DW_W'(DWELL - 1)) begin
            dwell_d = '0;
            if (want != state_q) begin
              state_d = want;
              step_d  = '0;
            end else begin
              step_d = (step_q == CH_W'(NUM_CH - 1)) ? '0 : step_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Enables come from the next state so channel leds update on the same
  // edge as the FSM (e.g. FILL wrap clears leds 1.. in that very cycle).
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (state_d)
        ST_ALL:   en_d[i] = 1'b1;
        ST_CHASE: en_d[i] = (step_d == CH_W'(i));
        ST_FILL:  en_d[i] = (CH_W'(i) <= step_d);
        default:  en_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  // Out-of-range targets are accepted but match no channel.
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_ready = ~|pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_vld[g] = accept && (cfg_ch == CH_W'(g));
    toggle_channel #(
      .CNT_W         (CNT_W),
      .DEFAULT_DELAY (DEFAULT_DELAY)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_d[g]),
      .wr_valid_i (wr_vld[g]),
      .wr_delay_i (cfg_delay),
      .led_o      (led[g]),
      .pending_o  (pend[g])
    );
  end

  assign step_idx = step_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Controller for a bank of toggle-type LED signal generators.
- Owns one programmable-period toggle channel per LED and a sequencing state machine.
- The state machine decides which channels run: all at once, one at a time (chase), or a growing group (fill).
- Sits between the top level and the LED pins, replacing fixed-delay generators with runtime-configurable ones.

Parameters:
- NUM_CH, 3, number of channels / LED outputs (2..8).
- CNT_W, 16, width of delay registers and per-channel counters.
- DWELL, 1000, cycles per sequencer step in chase and fill modes (≥2).
- DEFAULT_DELAY, 5, reset value of every channel delay register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = sequencer active, 0 = all channels off.
- mode  in  2  0=ALL, 1=CHASE, 2=FILL, 3=OFF.
- cfg_valid  in  1  delay-write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_delay  in  CNT_W  new delay value.
- led  out  NUM_CH  channel outputs, registered.
- step_idx  out  $clog2(NUM_CH)  current sequencer step.
- busy  out  1  1 when the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous, active-low; it clears all state.
  - Outputs on reset: led=0, step_idx=0, busy=0, cfg_ready=1.
  - Internal state on reset: FSM=IDLE, all delay regs=DEFAULT_DELAY, counters=0, no pending writes, dwell counter=0.
- Channel operation:
  - An enabled channel counts 0..delay.
  - At count==delay it toggles its led and restarts at 0, so the half-period is delay+1 cycles.
  - delay=0 toggles every cycle.
- Disabled channel:
  - Counter held at 0, led forced to 0.
  - On enable, it starts at phase 0; the first rise comes delay+1 cycles after the enable edge.
- FSM states: IDLE, ALL, CHASE, FILL.
  - IDLE: no channels enabled. When run=1 and mode≠3, go to the state matching mode on the next edge, with step_idx=0 and dwell counter=0.
  - Any state with run=0 or mode=3 returns to IDLE on the next edge. Leds are 0 the cycle after.
  - ALL: every channel enabled; the dwell counter is idle.
  - CHASE: only channel step_idx is enabled.
  - FILL: channels 0..step_idx are enabled.
  - In CHASE and FILL, the dwell counter counts 0..DWELL-1. At DWELL-1, step_idx advances and wraps NUM_CH-1→0, and the dwell counter restarts.
  - On a step change, newly enabled channels start at phase 0. Channels that stay enabled continue without disturbance.
  - FILL wrap from NUM_CH-1 to 0 disables channels 1..NUM_CH-1 in the same cycle.
- Mode changes:
  - From ALL, a mode change is taken on the next edge.
  - From CHASE or FILL, a mode change is deferred to the dwell boundary. At that boundary, step_idx=0 in the new state.
  - run=0 is never deferred.
- Config handshake:
  - cfg_ready=1 iff no write is pending.
  - An accepted write is stored as pending for cfg_ch, and cfg_ready drops the next cycle.
  - If the target channel is disabled, the pending value is applied on the next edge.
  - If it is enabled, the value is applied at its next toggle; the new delay governs the following half-period.
  - cfg_ready returns to 1 the cycle after application.
  - cfg_ch ≥ NUM_CH: the write is accepted and discarded; cfg_ready stays 1.
  - If a toggle and an application coincide, the toggle uses the old delay, and the counter restart uses the new one.
- Simultaneous events: a dwell boundary and run=0 in the same cycle go to IDLE. A disabled channel with a pending write applies it regardless of FSM state.

Decomposition:
- Package blink_pkg holds:
  - FSM state enum (IDLE, ALL, CHASE, FILL);
  - mode encodings MODE_ALL=0, MODE_CHASE=1, MODE_FILL=2, MODE_OFF=3.
- One sub-module, toggle_channel, instantiated NUM_CH times. Each instance owns:
  - counter, delay register, pending register and led flop;
  - inputs: enable, wr_valid, wr_delay;
  - outputs: led, pending.
- cfg_ready = NOR of all pending flags.

Test Plan (NUM_CH=3, CNT_W=8, DWELL=20, DEFAULT_DELAY=2):
- Reset release, run=1, mode=0 → busy=1 next edge; all three leds rise together 3 cycles later, then toggle every 3 cycles.
- run=1, mode=1 → led0 active for 20 cycles, then led1, then led2, then led0; step_idx 0,1,2,0; inactive leds stay 0.
- mode=2 → step0 only led0; step1 led0+led1; step2 all three; step3 only led0, with led1/led2 forced to 0 that cycle.
- Mode 0 running, write ch1 delay=5 → cfg_ready low until ch1's next toggle; ch1 half-period becomes 6 cycles; ch0/ch2 keep 3.
- Chase at step 2, rst_n pulsed low mid-dwell → led=0 and busy=0 immediately; after release and run=1, delays are back to 2 and step_idx=0.
- Idle: write cfg_ch=3 → no channel change, cfg_ready stays 1. Write ch0 delay=0 then run mode=0 → led0 toggles every cycle.
